// File: rtl/plic_pkg.sv
// Shared types and constants for the PLIC interrupt gateway.
package plic_pkg;

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PENDING  = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_e;

    localparam int PLIC_NO_IRQ          = 0;
    localparam int PLIC_DEFAULT_NUM_SRC = 8;

endpackage

// File: rtl/plic_gateway_cell.sv
// One interrupt source: 2-flop synchronizer, optional debounce
// (PLIC_GATEWAY_DEBOUNCE_EN), request detector, gateway FSM and edge latch.
module plic_gateway_cell
    import plic_pkg::*;
#(
    parameter bit EDGE_TRIG       = 1'b0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    input  logic claim_hit_i,
    input  logic complete_hit_i,
    output logic ip_o,
    output logic inflight_o
);

    logic      sync1_q, sync2_q;
    logic      filt;
    logic      prev_q;
    logic      rise;
    logic      req;
    logic      latch_q, latch_d;
    logic      consume;
    gw_state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PLIC_GATEWAY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;

    // Output flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= filt;
        end
    end

    assign rise = filt & ~prev_q;
    assign req  = EDGE_TRIG ? rise : filt;

    // Edge sources with a latched edge skip IDLE and re-pend on completion.
    assign consume = EDGE_TRIG && (state_q == GW_INFLIGHT) && complete_hit_i && latch_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GW_IDLE:     if (req) state_d = GW_PENDING;
            GW_PENDING:  if (claim_hit_i) state_d = GW_INFLIGHT;
            GW_INFLIGHT: if (complete_hit_i) state_d = consume ? GW_PENDING : GW_IDLE;
            default:     state_d = GW_IDLE;
        endcase
    end

    always_comb begin
        latch_d = 1'b0;
        if (EDGE_TRIG) begin
            latch_d = (latch_q & ~consume)
                    | (rise & ((state_q == GW_PENDING) || (state_q == GW_INFLIGHT)));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= GW_IDLE;
            latch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
        end
    end

    assign ip_o       = (state_q == GW_PENDING);
    assign inflight_o = (state_q == GW_INFLIGHT);

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway top: claim/complete ID decoding over NUM_SRC cells.
// Optional debounce is compiled in with PLIC_GATEWAY_DEBOUNCE_EN.
module plic_gateway
    import plic_pkg::*;
#(
    parameter int                 NUM_SRC         = PLIC_DEFAULT_NUM_SRC,
    parameter logic [NUM_SRC-1:0] EDGE_MASK       = '0,
    parameter int                 DEBOUNCE_CYCLES = 16,
    localparam int                ID_W            = $clog2(NUM_SRC + 1)
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               claim_valid_i,
    input  logic [ID_W-1:0]    claim_id_i,
    input  logic               complete_valid_i,
    input  logic [ID_W-1:0]    complete_id_i,
    output logic [NUM_SRC-1:0] ip_o,
    output logic [NUM_SRC-1:0] inflight_o
);

    logic claim_ok;
    logic complete_ok;

    // ID 0 never matches a cell; IDs above NUM_SRC fall through the decode.
    assign claim_ok    = claim_valid_i && (claim_id_i != ID_W'(PLIC_NO_IRQ));
    assign complete_ok = complete_valid_i && (complete_id_i != ID_W'(PLIC_NO_IRQ));

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cell
        localparam logic [ID_W-1:0] CELL_ID = ID_W'(gi + 1);

        plic_gateway_cell #(
            .EDGE_TRIG       (EDGE_MASK[gi]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .clk_i          (CLK100MHZ),
            .rst_ni         (CPU_RESETN),
            .src_i          (src_i[gi]),
            .claim_hit_i    (claim_ok && (claim_id_i == CELL_ID)),
            .complete_hit_i (complete_ok && (complete_id_i == CELL_ID)),
            .ip_o           (ip_o[gi]),
            .inflight_o     (inflight_o[gi])
        );
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed self-checking bench for plic_gateway (default build, no debounce).
module tb_plic_gateway;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 4;

    logic               clk;
    logic               rst_n;
    logic [NUM_SRC-1:0] src;
    logic               claim_valid;
    logic [ID_W-1:0]    claim_id;
    logic               complete_valid;
    logic [ID_W-1:0]    complete_id;
    logic [NUM_SRC-1:0] ip;
    logic [NUM_SRC-1:0] inflight;

    int checks = 0;
    int errors = 0;

    plic_gateway #(
        .NUM_SRC         (NUM_SRC),
        .EDGE_MASK       (8'h01),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .CLK100MHZ        (clk),
        .CPU_RESETN       (rst_n),
        .src_i            (src),
        .claim_valid_i    (claim_valid),
        .claim_id_i       (claim_id),
        .complete_valid_i (complete_valid),
        .complete_id_i    (complete_id),
        .ip_o             (ip),
        .inflight_o       (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_claim(input logic [ID_W-1:0] id);
        claim_valid = 1'b1;
        claim_id    = id;
        step(1);
        claim_valid = 1'b0;
        claim_id    = '0;
    endtask

    task automatic do_complete(input logic [ID_W-1:0] id);
        complete_valid = 1'b1;
        complete_id    = id;
        step(1);
        complete_valid = 1'b0;
        complete_id    = '0;
    endtask

    task automatic pulse_src0();
        src[0] = 1'b1;
        step(1);
        src[0] = 1'b0;
        step(1);
    endtask

    task automatic check(input string name, input logic [7:0] exp_ip, input logic [7:0] exp_inf);
        checks++;
        if (ip !== exp_ip || inflight !== exp_inf) begin
            errors++;
            $display("FAIL %s: ip=%h inflight=%h, required ip=%h inflight=%h",
                     name, ip, inflight, exp_ip, exp_inf);
        end else begin
            $display("ok   %s: ip=%h inflight=%h", name, ip, inflight);
        end
    endtask

    task automatic test_reset();
        #2;
        check("reset_asserted", 8'h00, 8'h00);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("reset_released", 8'h00, 8'h00);
    endtask

    task automatic test_level();
        src[2] = 1'b1;
        step(2);
        check("level_latency_2", 8'h00, 8'h00);
        step(1);
        check("level_latency_3", 8'h04, 8'h00);
        do_claim(4'd3);
        check("level_claim", 8'h00, 8'h04);
        do_complete(4'd3);
        check("level_complete", 8'h00, 8'h00);
        step(1);
        check("level_repend", 8'h04, 8'h00);
        src[2] = 1'b0;
        step(3);
        check("level_drop_held", 8'h04, 8'h00);
        do_claim(4'd3);
        do_complete(4'd3);
        step(2);
        check("level_clean", 8'h00, 8'h00);
    endtask

    task automatic test_edge();
        pulse_src0();
        step(1);
        check("edge_pend", 8'h01, 8'h00);
        do_claim(4'd1);
        check("edge_claim", 8'h00, 8'h01);
        pulse_src0();
        pulse_src0();
        pulse_src0();
        step(2);
        check("edge_inflight_hold", 8'h00, 8'h01);
        do_complete(4'd1);
        check("edge_repend", 8'h01, 8'h00);
        do_claim(4'd1);
        check("edge_claim2", 8'h00, 8'h01);
        do_complete(4'd1);
        check("edge_complete2", 8'h00, 8'h00);
        step(3);
        check("edge_no_extra", 8'h00, 8'h00);
    endtask

    task automatic test_invalid();
        src[2] = 1'b1;
        step(3);
        check("inv_setup", 8'h04, 8'h00);
        do_claim(4'd0);
        check("inv_claim0", 8'h04, 8'h00);
        do_claim(4'd9);
        check("inv_claim9", 8'h04, 8'h00);
        do_complete(4'd5);
        check("inv_complete5_idle", 8'h04, 8'h00);
        do_complete(4'd3);
        check("inv_complete3_pending", 8'h04, 8'h00);
        do_claim(4'd3);
        src[2] = 1'b0;
        step(2);
        do_complete(4'd3);
        step(2);
        check("inv_clean", 8'h00, 8'h00);
    endtask

    task automatic test_same_cycle();
        src[1] = 1'b1;
        src[3] = 1'b1;
        step(3);
        check("same_setup", 8'h0A, 8'h00);
        do_claim(4'd2);
        check("same_claim2", 8'h08, 8'h02);
        src[1] = 1'b0;
        src[3] = 1'b0;
        step(2);
        claim_valid    = 1'b1;
        claim_id       = 4'd4;
        complete_valid = 1'b1;
        complete_id    = 4'd2;
        step(1);
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
        check("same_cycle", 8'h00, 8'h08);
        do_complete(4'd4);
        step(1);
        check("same_clean", 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid();
        src[1] = 1'b1;
        pulse_src0();
        step(1);
        check("mid_setup", 8'h03, 8'h00);
        do_claim(4'd2);
        src[1] = 1'b0;
        check("mid_before_reset", 8'h01, 8'h02);
        rst_n = 1'b0;
        #1;
        check("mid_reset_async", 8'h00, 8'h00);
        step(2);
        rst_n = 1'b1;
        step(4);
        check("mid_after_release", 8'h00, 8'h00);
    endtask

    initial begin
        rst_n          = 1'b0;
        src            = '0;
        claim_valid    = 1'b0;
        claim_id       = '0;
        complete_valid = 1'b0;
        complete_id    = '0;
        test_reset();
        test_level();
        test_edge();
        test_invalid();
        test_same_cycle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
